regfile_writeback: RTL
======================

Name: regfile_writeback

Overview:
Writer side of the 32-entry register file write port. Accepts results from two producers (ALU and load unit) via valid/ready handshakes and buffers them in an in-order queue. Drains one entry per cycle onto the register file's wr_en/wr_addr/wr_data port. Exposes a forwarding lookup so the read side can see values still pending in the queue.

Parameters:
WIDTH, 32, data word width in bits
ADDR_SPACE, 5, register address width in bits
DEPTH, 4, queue entries; power of two, at least 2
ZERO_REGISTER, 5'b00000, hard-wired zero register address

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous, active-low reset
flush  input  1  synchronous queue clear
alu_valid  input  1  ALU result valid
alu_ready  output  1  ALU result accepted this cycle
alu_addr  input  ADDR_SPACE  ALU destination register
alu_data  input  WIDTH  ALU result
mem_valid  input  1  load result valid
mem_ready  output  1  load result accepted this cycle
mem_addr  input  ADDR_SPACE  load destination register
mem_data  input  WIDTH  load result
wr_en  output  1  register file write enable
wr_addr  output  ADDR_SPACE  register file write address
wr_data  output  WIDTH  register file write data
fwd1_addr  input  ADDR_SPACE  forwarding lookup address 1
fwd1_hit  output  1  pending write to fwd1_addr exists
fwd1_data  output  WIDTH  youngest pending value for fwd1_addr
fwd2_addr, fwd2_hit, fwd2_data  same as fwd1 (second lookup)
pending  output  $clog2(DEPTH)+1  current queue occupancy

Behaviour:
- Reset (rst_n=0, async): queue empty, pending=0, wr_en=0, wr_addr=0, wr_data=0, both fwd hits 0.
- Queue is circular: head/tail pointers wrap modulo DEPTH; occupancy counter ranges 0..DEPTH.
- free = DEPTH - pending, using the start-of-cycle value. Same-cycle pop gives no credit.
- mem_ready = (free >= 1) && !flush.
- alu_ready = !flush && ((free >= 2) || (free == 1 && !mem_valid)).
- alu_ready depends combinationally on mem_valid. The ALU never sees ready=1 when the load also takes the last slot.
- Push ordering: if both sources push in the same cycle, the mem entry is enqueued first (older), then the alu entry.
- Zero register: a push with addr == ZERO_REGISTER completes the handshake but stores nothing.
- Write port is driven combinationally from the queue head: wr_en = (pending != 0), with wr_addr/wr_data taken from the head entry. When empty, wr_addr=0 and wr_data=0.
- Pop: every cycle with wr_en=1, the head advances at the clock edge (the register file has no backpressure).
- Latency: a value pushed at edge N appears on the write port during cycle N+1 (if the queue was empty) and is written at edge N+1.
- Simultaneous push and pop: both take effect. Pending changes by (pushes - pop).
- flush: at the edge, queue empties and pending becomes 0. Same-cycle pushes are refused (ready=0). wr_en still reflects the head during the flush cycle.
- Reset mid-operation: contents are discarded immediately and outputs return to reset values asynchronously.

Optional Feature:
- Macro WB_FWD_EN.
- Defined: fwdN_hit=1 when any valid queue entry has addr == fwdN_addr. fwdN_data is the youngest such entry. fwdN_addr == ZERO_REGISTER never hits.
- Not defined: fwdN_hit=0 and fwdN_data=0 constantly, and the match logic is not synthesised.

Test Plan:
- Reset then single ALU push (addr=5, data=32'hDEADBEEF) -> next cycle wr_en=1, wr_addr=5, wr_data=32'hDEADBEEF; following cycle wr_en=0, pending=0.
- Both push in one cycle (mem addr=3 data=1, alu addr=4 data=2) from empty -> write port shows addr 3, then addr 4 on consecutive cycles.
- Fill to DEPTH=4 by holding both valids with the queue never draining faster than fill -> mem_ready=0 at pending=4. At pending=3 with mem_valid=1, alu_ready=0. No entry is lost or duplicated.
- Push to addr 0 (data=32'hFFFFFFFF) -> ready=1, pending unchanged, wr_en never asserted for it.
- WB_FWD_EN: queue holds addr 7 = 10 then addr 7 = 20 -> fwd1_addr=7 gives hit=1, data=20. fwd2_addr=0 gives hit=0.
- pending=3, assert flush with alu_valid=1 -> alu_ready=0; next cycle pending=0, wr_en=0. rst_n pulse mid-fill -> outputs go to zero without a clock edge.

Source files
------------

// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if: bundles the producer handshakes, the register-file
// write port, the forwarding lookups and the occupancy output of the
// writeback queue. The slave modport is the queue; the master modport is
// whatever drives the producers and consumes the write port.
interface regfile_writeback_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_SPACE = 5,
    parameter int DEPTH      = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Queue control
    logic                  flush;

    // ALU producer
    logic                  alu_valid;
    logic                  alu_ready;
    logic [ADDR_SPACE-1:0] alu_addr;
    logic [WIDTH-1:0]      alu_data;

    // Load producer
    logic                  mem_valid;
    logic                  mem_ready;
    logic [ADDR_SPACE-1:0] mem_addr;
    logic [WIDTH-1:0]      mem_data;

    // Register file write port
    logic                  wr_en;
    logic [ADDR_SPACE-1:0] wr_addr;
    logic [WIDTH-1:0]      wr_data;

    // Forwarding lookups
    logic [ADDR_SPACE-1:0] fwd1_addr;
    logic                  fwd1_hit;
    logic [WIDTH-1:0]      fwd1_data;
    logic [ADDR_SPACE-1:0] fwd2_addr;
    logic                  fwd2_hit;
    logic [WIDTH-1:0]      fwd2_data;

    // Occupancy
    logic [CNT_W-1:0]      pending;

    modport slave (
        input  flush,
        input  alu_valid, alu_addr, alu_data,
        output alu_ready,
        input  mem_valid, mem_addr, mem_data,
        output mem_ready,
        output wr_en, wr_addr, wr_data,
        input  fwd1_addr, fwd2_addr,
        output fwd1_hit, fwd1_data, fwd2_hit, fwd2_data,
        output pending
    );

    modport master (
        output flush,
        output alu_valid, alu_addr, alu_data,
        input  alu_ready,
        output mem_valid, mem_addr, mem_data,
        input  mem_ready,
        input  wr_en, wr_addr, wr_data,
        output fwd1_addr, fwd2_addr,
        input  fwd1_hit, fwd1_data, fwd2_hit, fwd2_data,
        input  pending
    );
endinterface

// File: rtl/regfile_writeback.sv
// regfile_writeback: in-order writeback queue in front of the register file
// write port. Two producers (load unit and ALU) push through valid/ready;
// the head entry is presented combinationally on wr_en/wr_addr/wr_data and
// retired every cycle it is shown. Pushes to ZERO_REGISTER are accepted and
// dropped.
//
// Optional feature: define WB_FWD_EN to build the forwarding lookups that let
// the read side see the youngest pending value for an address. Without it the
// fwd outputs are tied to zero and no match logic exists.
module regfile_writeback #(
    parameter int                    WIDTH         = 32,
    parameter int                    ADDR_SPACE    = 5,
    parameter int                    DEPTH         = 4,
    parameter logic [ADDR_SPACE-1:0] ZERO_REGISTER = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_writeback_if.slave   bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef struct packed {
        logic [ADDR_SPACE-1:0] addr;
        logic [WIDTH-1:0]      data;
    } entry_t;

    // Queue storage and bookkeeping
    entry_t           r_q [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    // Handshake / push / pop decode
    logic [CNT_W-1:0] w_free;
    logic             w_mem_ready;
    logic             w_alu_ready;
    logic             w_mem_push;
    logic             w_alu_push;
    logic             w_pop;
    logic [1:0]       w_n_push;
    logic [PTR_W-1:0] w_alu_slot;

    // Readiness uses start-of-cycle occupancy only; a same-cycle pop frees
    // nothing, so the queue can never overflow. The ALU yields the last slot
    // to a waiting load, which keeps the mem-before-alu ordering simple.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_free      = DEPTH_C - r_count;
        w_mem_ready = (w_free >= CNT_W'(1)) && !bus.flush;
        w_alu_ready = !bus.flush &&
                      ((w_free >= CNT_W'(2)) ||
                       ((w_free == CNT_W'(1)) && !bus.mem_valid));
        // A handshake to the zero register completes but stores nothing.
        w_mem_push  = bus.mem_valid && w_mem_ready && (bus.mem_addr != ZERO_REGISTER);
        w_alu_push  = bus.alu_valid && w_alu_ready && (bus.alu_addr != ZERO_REGISTER);
        w_pop       = (r_count != '0);
        w_n_push    = {1'b0, w_mem_push} + {1'b0, w_alu_push};
        // The load entry is older, so the ALU entry lands behind it.
        w_alu_slot  = w_mem_push ? (r_tail + PTR_W'(1)) : r_tail;
    end

    assign bus.mem_ready = w_mem_ready;
    assign bus.alu_ready = w_alu_ready;
    assign bus.pending   = r_count;

    // Pointers and occupancy: reset/flush empty the queue, otherwise apply pushes and pop together.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (bus.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_pop);
            r_tail  <= r_tail + PTR_W'(w_n_push);
            r_count <= r_count + CNT_W'(w_n_push) - CNT_W'(w_pop);
        end
    end

    // Entry storage: written at the tail slots chosen by the push decode.
    // NOTE: the storage array has no reset; an entry is only ever read once the occupancy count covers it.
    always_ff @(posedge clk) begin
        if (w_mem_push) begin
            r_q[r_tail] <= '{addr: bus.mem_addr, data: bus.mem_data};
        end
        if (w_alu_push) begin
            r_q[w_alu_slot] <= '{addr: bus.alu_addr, data: bus.alu_data};
        end
    end

    // Write port: present the head entry whenever the queue is non-empty, zeros otherwise.
    always_comb begin
        bus.wr_en   = w_pop;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        if (w_pop) begin
            bus.wr_addr = r_q[r_head].addr;
            bus.wr_data = r_q[r_head].data;
        end
    end

`ifdef WB_FWD_EN
    // Scan live entries oldest to youngest so the last match wins; returns {hit, data}.
    function automatic logic [WIDTH:0] fwd_lookup(input logic [ADDR_SPACE-1:0] addr);
        logic [WIDTH:0]   result;
        logic [PTR_W-1:0] idx;
        result = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = r_head + PTR_W'(i);
            if ((CNT_W'(i) < r_count) && (r_q[idx].addr == addr) &&
                (addr != ZERO_REGISTER)) begin
                result = {1'b1, r_q[idx].data};
            end
        end
        return result;
    endfunction

    // Forwarding lookups: youngest pending value for each requested address.
    always_comb begin
        {bus.fwd1_hit, bus.fwd1_data} = fwd_lookup(bus.fwd1_addr);
        {bus.fwd2_hit, bus.fwd2_data} = fwd_lookup(bus.fwd2_addr);
    end
`else
    // Forwarding disabled: lookups never hit.
    assign bus.fwd1_hit  = 1'b0;
    assign bus.fwd1_data = '0;
    assign bus.fwd2_hit  = 1'b0;
    assign bus.fwd2_data = '0;
`endif

endmodule
